// File: rtl/wbl_key_readback.sv
// wbl_key_readback: rebuilds the eleven AES-128 round keys from WBL words read back from the CIM array.
// True and complement copies are cross-checked; keys stream out over valid/ready once a frame ends.
module wbl_key_readback #(
  parameter bit CHECK_PAD = 1'b1,
  parameter int CMP_BASE  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_addr,
  input  logic [63:0]  in_word,
  input  logic         in_last,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic [127:0] key_out,
  output logic         frame_done,
  output logic         err_cmp,
  output logic         err_pad,
  output logic         err_missing
);
  localparam logic [5:0] CB = 6'(CMP_BASE);
  typedef enum logic {S_COLLECT, S_EMIT} state_t;
  state_t         r_state, w_state_nx;
  logic [3:0]     r_beat, r_idx;
  logic [5:0]     r_addr;
  logic [2:0]     r_mask;
  logic           r_cmp_mode, r_start, r_done, r_err_cmp, r_err_pad, r_err_miss;
  logic [127:0]   r_key;
  logic [127:0]   r_store [0:10];
  logic [127:0]   w_store [0:10];
  logic           w_acc, w_true, w_comp, w_grp, w_cmp, w_end, w_hs, w_mis, w_pad_bad;
  logic [5:0]     w_addr, w_off;
  logic [1:0]     w_g;
  logic [2:0]     w_mask_eff, w_mask_nx;
  logic [3:0]     w_rnd;
  logic [6:0]     w_pos;
  logic           w_d;
  logic           w_unused;
  assign w_unused   = ^in_word[31:0];
  assign in_ready   = r_state == S_COLLECT;
  assign rk_valid   = r_state == S_EMIT;
  assign rk_idx     = r_idx;
  assign rk_data    = rk_valid ? r_store[r_idx] : '0;
  assign key_out    = r_key;
  assign frame_done = r_done;
  assign err_cmp    = r_err_cmp;
  assign err_pad    = r_err_pad;
  assign err_missing = r_err_miss;
  assign w_acc      = in_valid & in_ready;
  assign w_hs       = rk_valid & rk_ready;
  assign w_addr     = (r_beat == 4'd0) ? in_addr : r_addr;
  assign w_off      = w_addr - CB;
  assign w_true     = w_addr < 6'd3;
  assign w_comp     = (w_addr >= CB) && (w_off < 6'd3);
  assign w_grp      = w_true | w_comp;
  assign w_g        = w_true ? w_addr[1:0] : w_off[1:0];
  assign w_mask_eff = r_start ? 3'b000 : r_mask;
  // Compare-vs-write is decided once per group on beat 0 and held for its remaining beats.
  assign w_cmp      = w_comp & ((r_beat == 4'd0) ? w_mask_eff[w_g] : r_cmp_mode);
  assign w_mask_nx  = w_mask_eff | ((w_grp && r_beat == 4'd15) ? 3'(1 << w_g) : 3'b000);
  assign w_end      = w_acc & (r_beat == 4'd15) & in_last;
  always_comb begin
    w_store   = r_store;
    w_mis     = 1'b0;
    w_pad_bad = 1'b0;
    w_rnd     = '0;
    w_pos     = '0;
    w_d       = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        w_d   = in_word[63-8*c-r] ^ w_comp;
        w_rnd = {w_g, 2'(c)};
        w_pos = {~3'(r), ~r_beat[3], r_beat[2:0]};
        if (w_acc && w_grp) begin
          if (w_rnd == 4'd11) w_pad_bad = w_pad_bad | w_d;
          else if (w_cmp) w_mis = w_mis | (r_store[w_rnd][w_pos] != w_d);
          else w_store[w_rnd][w_pos] = w_d;
        end
      end
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = (r_state == S_COLLECT) ? (w_end ? S_EMIT : S_COLLECT)
                                        : ((w_hs && r_idx == 4'd10) ? S_COLLECT : S_EMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_COLLECT;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat     <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_cmp_mode <= 1'b0;
      r_start    <= 1'b1;
      r_done     <= 1'b0;
      r_err_cmp  <= 1'b0;
      r_err_pad  <= 1'b0;
      r_err_miss <= 1'b0;
      r_key      <= '0;
      for (int i = 0; i < 11; i++) r_store[i] <= '0;
    end else begin
      r_store <= w_store;
      if (w_acc) begin
        r_beat     <= r_beat + 4'd1;
        r_mask     <= w_mask_nx;
        r_start    <= 1'b0;
        r_done     <= w_end | (r_done & ~r_start);
        r_err_cmp  <= (r_err_cmp & ~r_start) | w_mis;
        r_err_pad  <= (r_err_pad & ~r_start) | (CHECK_PAD & w_pad_bad);
        r_err_miss <= (r_err_miss & ~r_start) | (w_end & (w_mask_nx != 3'b111));
        if (r_beat == 4'd0) begin
          r_addr     <= in_addr;
          r_cmp_mode <= w_cmp;
        end
        if (w_end) r_key <= w_store[0];
      end
      if (w_hs) begin
        r_idx <= (r_idx == 4'd10) ? 4'd0 : r_idx + 4'd1;
        if (r_idx == 4'd10) r_start <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wbl_key_readback.sv
// tb_wbl_key_readback: directed scenarios built from the FIPS-197 key schedule of 2b7e1516...4f3c.
module tb_wbl_key_readback;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_last, rk_ready;
  logic [5:0]   in_addr;
  logic [63:0]  in_word;
  logic         in_ready, rk_valid, frame_done, err_cmp, err_pad, err_missing;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data, key_out;
  int n_cmp = 0;
  int n_fail = 0;
  logic [127:0] fips   [0:11];
  logic [127:0] exp_rk [0:10];

  wbl_key_readback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_word(in_word), .in_last(in_last), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_idx(rk_idx), .rk_data(rk_data), .key_out(key_out), .frame_done(frame_done),
    .err_cmp(err_cmp), .err_pad(err_pad), .err_missing(err_missing)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] gen_word(input int g, input bit comp, input bit zero, input int n);
    logic [63:0] w;
    logic [127:0] k;
    int rnd, j;
    w = {32'h0, 32'hC3A5_5A3C};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 8; r++) begin
        rnd = 4*g + c;
        j = 2*r + ((n >= 8) ? 1 : 0);
        k = zero ? 128'h0 : fips[rnd];
        w[63-8*c-r] = k[120-8*j+(n%8)] ^ comp;
      end
    end
    return w;
  endfunction

  task automatic send_group(input logic [5:0] addr, input int g, input bit comp, input bit zero,
                            input bit last, input bit noise, input bit flip, input bit padz);
    logic [63:0] w;
    for (int n = 0; n < 16; n++) begin
      w = gen_word(g, comp, zero, n);
      if (n == 0 && flip) w[63] = ~w[63];
      if (n == 0 && padz) w[39] = 1'b0;
      in_valid = 1'b1;
      in_addr  = (n == 0) ? addr : ~addr;
      in_word  = w;
      in_last  = (n == 15) ? last : noise;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_emit(input string tag, input logic [2:0] exp_err, input logic [127:0] exp_key);
    n_cmp++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL %s rk_valid: got %b want 1", tag, rk_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s in_ready: got %b want 0", tag, in_ready); end
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL %s frame_done: got %b want 1", tag, frame_done); end
    n_cmp++; if ({err_cmp, err_pad, err_missing} !== exp_err) begin n_fail++; $display("FAIL %s errs(cmp,pad,miss): got %b want %b", tag, {err_cmp, err_pad, err_missing}, exp_err); end
    n_cmp++; if (key_out !== exp_key) begin n_fail++; $display("FAIL %s key_out: got %h want %h", tag, key_out, exp_key); end
    rk_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (rk_idx !== 4'(i)) begin n_fail++; $display("FAIL %s rk_idx: got %0d want %0d", tag, rk_idx, i); end
      n_cmp++; if (rk_data !== exp_rk[i]) begin n_fail++; $display("FAIL %s rk%0d: got %h want %h", tag, i, rk_data, exp_rk[i]); end
      @(posedge clk); #1;
    end
    rk_ready = 1'b0;
    n_cmp++; if ({rk_valid, in_ready, frame_done} !== 3'b011) begin n_fail++; $display("FAIL %s post-emit valid/ready/done: got %b want 011", tag, {rk_valid, in_ready, frame_done}); end
  endtask

  task automatic set_exp_fips();
    for (int i = 0; i < 11; i++) exp_rk[i] = fips[i];
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; rk_ready = 1'b0; in_addr = '0; in_word = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if ({in_ready, rk_valid, frame_done} !== 3'b100) begin n_fail++; $display("FAIL reset ready/valid/done: got %b want 100", {in_ready, rk_valid, frame_done}); end
    n_cmp++; if ({err_cmp, err_pad, err_missing} !== 3'b000) begin n_fail++; $display("FAIL reset errs: got %b want 000", {err_cmp, err_pad, err_missing}); end
    n_cmp++; if (rk_idx !== 4'd0 || rk_data !== 128'h0 || key_out !== 128'h0) begin n_fail++; $display("FAIL reset idx/data/key: got %0d %h %h want 0", rk_idx, rk_data, key_out); end
  endtask

  task automatic test_true_copy();
    send_group(6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_group(6'd1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_group(6'd2, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    set_exp_fips();
    run_emit("true_copy", 3'b000, fips[0]);
  endtask

  task automatic test_both_copies();
    n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL both frame_done_before: got %b want 1", frame_done); end
    send_group(6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL both frame_done_cleared: got %b want 0", frame_done); end
    send_group(6'd1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd32, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd33, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd34, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_exp_fips();
    run_emit("both_copies", 3'b000, fips[0]);
  endtask

  task automatic test_cmp_error();
    send_group(6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd32, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd33, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_group(6'd34, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_exp_fips();
    run_emit("cmp_error", 3'b100, fips[0]);
  endtask

  task automatic test_missing();
    send_group(6'd0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) exp_rk[i] = (i < 8) ? 128'h0 : fips[i];
    run_emit("missing", 3'b001, 128'h0);
  endtask

  task automatic test_comp_only();
    send_group(6'd32, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd33, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd34, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_exp_fips();
    run_emit("comp_only", 3'b000, fips[0]);
  endtask

  task automatic test_pad_error();
    send_group(6'd32, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd33, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd34, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    set_exp_fips();
    run_emit("pad_error", 3'b010, fips[0]);
  endtask

  task automatic test_discard();
    send_group(6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_exp_fips();
    run_emit("discard", 3'b000, fips[0]);
  endtask

  task automatic test_back_to_back();
    send_group(6'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_group(6'd2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rk_data !== fips[i]) begin n_fail++; $display("FAIL bp rk%0d: got %h want %h", i, rk_data, fips[i]); end
      @(posedge clk); #1;
    end
    rk_ready = 1'b0;
    repeat (5) begin
      n_cmp++; if ({rk_valid, in_ready, rk_idx} !== {1'b1, 1'b0, 4'd4}) begin n_fail++; $display("FAIL bp hold valid/ready/idx: got %b %b %0d want 1 0 4", rk_valid, in_ready, rk_idx); end
      n_cmp++; if (rk_data !== fips[4]) begin n_fail++; $display("FAIL bp hold rk_data: got %h want %h", rk_data, fips[4]); end
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rk_ready = 1'b0;
    n_cmp++; if (rk_idx !== 4'd6 || rk_data !== fips[6]) begin n_fail++; $display("FAIL bp at idx6: got %0d %h want 6 %h", rk_idx, rk_data, fips[6]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if ({rk_valid, in_ready, frame_done} !== 3'b010) begin n_fail++; $display("FAIL rst_emit valid/ready/done: got %b want 010", {rk_valid, in_ready, frame_done}); end
    n_cmp++; if ({err_cmp, err_pad, err_missing} !== 3'b000 || rk_idx !== 4'd0 || key_out !== 128'h0) begin n_fail++; $display("FAIL rst_emit errs/idx/key: got %b %0d %h want 000 0 0", {err_cmp, err_pad, err_missing}, rk_idx, key_out); end
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips[11] = 128'h0;
    test_reset();
    test_true_copy();
    test_both_copies();
    test_cmp_error();
    test_missing();
    test_comp_only();
    test_pad_error();
    test_discard();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wbl_key_readback.md
Name: wbl_key_readback

Overview:
- Inverse of `wbl_key_gen`: rebuilds the eleven AES-128 round keys from WBL words read back from the DRAM-CIM array.
- Serial 64-bit word stream in: 16 words per array address.
- Bits are de-interleaved into a round-key store; true and complement copies are cross-checked.
- After a frame ends, round keys rk0..rk10 stream out over valid/ready. Sits between the array read-out path and the AES datapath / key-integrity monitor.

Parameters:
- CHECK_PAD, 1: when 1, the pad nibble bit (address 2/34, column 3) is checked.
- CMP_BASE, 32: address offset of the complement copies (true groups at 0..2, complement at CMP_BASE..CMP_BASE+2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  word beat valid
- in_ready  out  1  block can accept a beat
- in_addr  in  6  array address; sampled on beat 0 of each 16-beat group only
- in_word  in  64  one WBL word; beat n carries WBL(n+1)
- in_last  in  1  frame end; honoured only on beat 15
- rk_valid  out  1  round key valid
- rk_ready  in  1  consumer accepts round key
- rk_idx  out  4  round number 0..10
- rk_data  out  128  round key, byte 0 in [127:120]
- key_out  out  128  rk0 (cipher key), stable while frame_done=1
- frame_done  out  1  high from first emit until next frame's first accepted beat
- err_cmp  out  1  complement copy disagrees with true copy (sticky per frame)
- err_pad  out  1  pad bit wrong (sticky per frame)
- err_missing  out  1  frame ended without all three groups (sticky per frame)

Behaviour:
- Reset: state COLLECT, beat counter 0, group mask 0, store zero. Outputs: in_ready=1, rk_valid=0, rk_idx=0, rk_data=0, key_out=0, frame_done=0, all err flags 0. Reset mid-emit aborts emission immediately.
- Beat counter (4 bits) advances on every accepted beat and wraps 15→0. The group address is latched on beat 0.
- Decode for beat n, word w: p = n mod 8; odd-byte select = (n ≥ 8).
- For column c in 0..3 and row r in 0..7, bit d = w[63-8c-r].
- d goes to round rnd, byte j = 2r + (odd ? 1 : 0), bit p.
- Group g = addr (true) or addr-CMP_BASE (complement); rnd = 4g + c.
- Column 3 of group 2 is the pad bit, not key data: expected 0 (true) or 1 (complement); a mismatch sets err_pad when CHECK_PAD=1.
- Word bits [31:0] are ignored.
- Complement groups: decoded bits are inverted first.
  - If the group's mask bit is already set, compare against the store; any difference sets err_cmp.
  - If the mask bit is clear, write the store and set the mask bit.
  - A true group always overwrites and sets its mask bit.
- Other addresses (3..CMP_BASE-1, above CMP_BASE+2): beats are accepted and discarded.
- FSM:
  - COLLECT→EMIT: on an accepted beat 15 with in_last=1. in_ready=0 in EMIT. If mask≠111 at that point, err_missing=1.
  - EMIT: rk_valid=1 starting the cycle after the last beat; rk_idx starts at 0. Each rk_valid & rk_ready advances rk_idx.
  - EMIT→COLLECT: on the handshake with rk_idx=10; rk_valid=0 and in_ready=1 the next cycle.
  - rk_data and rk_idx are held stable while rk_valid=1 and rk_ready=0.
- key_out latches rk0 on COLLECT→EMIT. frame_done asserts on that same edge.
- First accepted beat of a new frame clears: mask, err flags, frame_done. The store is not cleared.
- in_last on beats 0..14 is ignored.
- Complement and true copies of the same group in one beat are impossible; groups are processed in arrival order.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c, addresses 0,1,2 from `wbl_key_gen`, in_last on the 48th beat → rk0 = 2b7e1516…4f3c, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, all err flags 0, key_out equals the key.
- Same key, addresses 0,1,2,32,33,34 → identical keys, err_cmp=0, err_pad=0. Flip in_word[63] on beat 0 of address 33 → err_cmp=1.
- Complement only (32,33,34) → same rk0..rk10 as the first test. Force the pad bit to 0 in address 34 → err_pad=1.
- Only addresses 0,1 then in_last → err_missing=1, rk8..rk10 reflect the stale store, 11 keys still emitted.
- rk_ready low for 5 cycles at rk_idx=4 → rk_data stable, in_ready=0 throughout. Assert rst at rk_idx=6 → next cycle rk_valid=0, in_ready=1, flags 0.
- Address 5 group interleaved between 0 and 1 → discarded; keys match the first test.
